// File: rtl/division.sv
// ============================================================================
// Module   : division
// Brief    : Multi-cycle unsigned restoring divider, one quotient bit per clock
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module division #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done
);

    localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_rem;

    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_dvd_nxt;

    // The dividend register doubles as the quotient: dividend bits leave at
    // the MSB while quotient bits enter at the LSB.
    always_comb begin
        w_rem_sh  = {r_rem, r_dvd[WIDTH-1]};
        w_diff    = w_rem_sh - {1'b0, r_dvs};
        w_qbit    = ~w_diff[WIDTH];
        w_rem_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
        w_dvd_nxt = {r_dvd[WIDTH-2:0], w_qbit};
    end

    assign busy = (r_state == S_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            q       <= '0;
            r       <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dvd   <= a;
                        r_dvs   <= b;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_dvd <= w_dvd_nxt;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        q       <= w_dvd_nxt;
                        r       <= w_rem_nxt;
                        done    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_division.sv
// ============================================================================
// Module   : tb_division
// Brief    : Scoreboard bench for the restoring divider
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_division;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         busy;
    logic         done;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } exp_t;

    exp_t         sb[$];
    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] hold_q = '0;
    logic [W-1:0] hold_r = '0;

    always #5 clk = ~clk;

    division #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division; divide-by-zero yields all ones / dividend.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.a = x;
        e.b = y;
        if (y == '0) begin
            e.q = '1;
            e.r = x;
        end else begin
            e.q = x / y;
            e.r = x % y;
        end
        return e;
    endfunction

    // Monitor: compare on every done pulse, check results hold while busy.
    exp_t mon_e;
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 expected no pending result");
                end else begin
                    mon_e = sb.pop_front();
                    check("q", {32'b0, q}, {32'b0, mon_e.q});
                    check("r", {32'b0, r}, {32'b0, mon_e.r});
                    if (mon_e.b != '0) begin
                        check("invariant", {32'b0, q} * {32'b0, mon_e.b} + {32'b0, r}, {32'b0, mon_e.a});
                        check("r_lt_b", {63'b0, (r < mon_e.b)}, 64'd1);
                    end
                    hold_q = mon_e.q;
                    hold_r = mon_e.r;
                end
            end else if (busy === 1'b1) begin
                check("hold_q", {32'b0, q}, {32'b0, hold_q});
                check("hold_r", {32'b0, r}, {32'b0, hold_r});
            end
        end
    end

    task automatic run_div(input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        @(posedge clk);
        sb.push_back(model(x, y));
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        check("busy_after_launch", {63'b0, busy}, 64'd1);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("latency", 64'(n), 64'(W));
        @(negedge clk);
        check("done_pulse_width", {63'b0, done}, 64'd0);
        check("busy_after_done", {63'b0, busy}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int m;
        int pulses;
        logic [W-1:0] x;
        logic [W-1:0] y;

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_q", {32'b0, q}, 64'd0);
        check("rst_r", {32'b0, r}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        reset = 1'b0;

        run_div(32'd100, 32'd7);
        run_div(32'hFFFF_FFFF, 32'd1);
        run_div(32'hFFFF_FFFF, 32'h0001_0000);
        run_div(32'd3, 32'd10);
        run_div(32'd5, 32'd0);

        // Start held high: mid-run operand change ignored, then relaunch.
        @(negedge clk);
        start = 1'b1;
        a     = 32'd100;
        b     = 32'd7;
        @(posedge clk);
        sb.push_back(model(32'd100, 32'd7));
        @(negedge clk);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 4) begin
                a = 32'd50;
                b = 32'd5;
            end
        end
        check("held_start_latency", 64'(n), 64'(W));
        sb.push_back(model(32'd50, 32'd5));
        @(negedge clk);
        m = 1;
        start = 1'b0;
        check("relaunch_busy", {63'b0, busy}, 64'd1);
        while (done !== 1'b1 && m < 100) begin
            @(negedge clk);
            m++;
        end
        check("relaunch_spacing", 64'(m), 64'(W + 1));
        @(negedge clk);

        // Abort via reset mid-run.
        @(negedge clk);
        start = 1'b1;
        a     = 32'd1000;
        b     = 32'd3;
        @(posedge clk);
        sb.push_back(model(32'd1000, 32'd3));
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset  = 1'b1;
        sb.delete();
        hold_q = '0;
        hold_r = '0;
        @(negedge clk);
        check("abort_q", {32'b0, q}, 64'd0);
        check("abort_r", {32'b0, r}, 64'd0);
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_done", {63'b0, done}, 64'd0);
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("no_done_after_abort", 64'(pulses), 64'd0);
        run_div(32'd1000, 32'd3);

        for (int i = 0; i < 200; i++) begin
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = '0;
                1: y = 32'd1;
                2: y = x;
                3: x = '0;
                4: begin x[W-1] = 1'b1; y[W-1] = 1'b1; end
                5: y = y >> $urandom_range(0, 31);
                6: x[W-1] = 1'b1;
                default: ;
            endcase
            run_div(x, y);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
